// File: rtl/game_pkg.sv
// Shared constants and types for the player / formation blocks.
package game_pkg;

   // enemy projectile bus layout: four 9-bit x slots then one 10-bit x slot
   localparam int NUM_SLOTS = 5;
   localparam int SLOT_XW   = 9;
   localparam int SLOT4_XW  = 10;
   localparam int SLOT_YW   = 9;
   localparam int EX_W      = 4 * SLOT_XW + SLOT4_XW;   // 46
   localparam int EY_W      = NUM_SLOTS * SLOT_YW;      // 45

   // width used for every x/y comparison, wide enough that differences never wrap
   localparam int CW = 11;

   localparam int SCREEN_H = 480;
   localparam int SCREEN_W = 640;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIVE = 2'd1,
      HIT   = 2'd2,
      DEAD  = 2'd3
   } cannon_state_t;

   // bit offset of slot i in either packed bus
   function automatic int slot_x_lsb(input int i);
      return SLOT_XW * i;
   endfunction

endpackage

// File: rtl/slot_hit_cmp.sv
// Box test of one enemy projectile slot against the player ship.
module slot_hit_cmp
   import game_pkg::*;
#(
   parameter int PLAYER_Y   = 440,
   parameter int HIT_HALF_W = 10,
   parameter int HIT_H      = 20
) (
   input  logic [CW-1:0]      slot_x,
   input  logic [SLOT_YW-1:0] slot_y,
   input  logic [9:0]         player_x,
   output logic               hit
);

   localparam logic [CW-1:0] HALF_W = CW'(HIT_HALF_W);
   localparam logic [CW-1:0] Y_LO   = CW'(PLAYER_Y);
   localparam logic [CW-1:0] Y_HI   = CW'(PLAYER_Y + HIT_H);

   logic [CW-1:0] px;
   logic [CW-1:0] sy;
   logic [CW-1:0] dx;

   // absolute x distance and vertical window; y = 0 marks an empty slot
   always_comb begin
      px  = {1'b0, player_x};
      sy  = {2'b0, slot_y};
      dx  = (slot_x >= px) ? (slot_x - px) : (px - slot_x);
      hit = (slot_y != '0) && (dx < HALF_W) && (sy >= Y_LO) && (sy < Y_HI);
   end

endmodule

// File: rtl/player_cannon.sv
// Player ship, single player projectile, enemy-hit detection and lives.
module player_cannon
   import game_pkg::*;
#(
   parameter int PLAYER_Y     = 440,
   parameter int X_MIN        = 100,
   parameter int X_MAX        = 540,
   parameter int X_START      = 320,
   parameter int LIVES        = 3,
   parameter int SHOT_STEP    = 4,
   parameter int INVULN_TICKS = 60,
   parameter int HIT_HALF_W   = 10,
   parameter int HIT_H        = 20
) (
   input  logic            clk_4,
   input  logic            clr,
   input  logic            play,
   input  logic            tick,
   input  logic            btn_left,
   input  logic            btn_right,
   input  logic            btn_fire,
   input  logic            collision,
   input  logic [EX_W-1:0] enemy_projectiles_x,
   input  logic [EY_W-1:0] enemy_projectiles_y,
   output logic [9:0]      projectiles_x,
   output logic [9:0]      projectiles_y,
   output logic [9:0]      player_x,
   output logic [1:0]      lives,
   output logic            player_hit,
   output logic            game_over
);

   localparam int            INV_W   = $clog2(INVULN_TICKS + 1);
   localparam logic [9:0]    XMIN_V  = 10'(X_MIN);
   localparam logic [9:0]    XMAX_V  = 10'(X_MAX);
   localparam logic [9:0]    XSTRT_V = 10'(X_START);
   localparam logic [9:0]    SHOT_Y  = 10'(PLAYER_Y - 10);
   localparam logic [9:0]    STEP_V  = 10'(SHOT_STEP);
   localparam logic [1:0]    LIVES_V = 2'(LIVES);
   localparam logic [INV_W-1:0] INV_V = INV_W'(INVULN_TICKS);

   cannon_state_t         state, nxt;
   logic [EX_W-1:0]       ex_q;
   logic [EY_W-1:0]       ey_q;
   logic [NUM_SLOTS-1:0]  slot_hit;
   logic                  hit_any;
   logic                  fire_q;
   logic                  fire_rise;
   logic [INV_W-1:0]      inv_cnt;
   logic                  active, move_en, fire_ok, hit_acc;

   // enemy bus is registered so the box test works on a stable snapshot
   always_ff @(posedge clk_4 or negedge clr) begin
      if (!clr) begin
         ex_q   <= '0;
         ey_q   <= '0;
         fire_q <= 1'b0;
      end else begin
         ex_q   <= enemy_projectiles_x;
         ey_q   <= enemy_projectiles_y;
         fire_q <= btn_fire;
      end
   end

   assign fire_rise = btn_fire & ~fire_q;

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      logic [CW-1:0] sx;
      if (i == NUM_SLOTS - 1) begin : g_wide
         assign sx = {1'b0, ex_q[slot_x_lsb(i) +: SLOT4_XW]};
      end else begin : g_narrow
         assign sx = {2'b0, ex_q[slot_x_lsb(i) +: SLOT_XW]};
      end
      slot_hit_cmp #(
         .PLAYER_Y  (PLAYER_Y),
         .HIT_HALF_W(HIT_HALF_W),
         .HIT_H     (HIT_H)
      ) u_cmp (
         .slot_x  (sx),
         .slot_y  (ey_q[SLOT_YW*i +: SLOT_YW]),
         .player_x(player_x),
         .hit     (slot_hit[i])
      );
   end

   assign hit_any = |slot_hit;

   // state register
   always_ff @(posedge clk_4 or negedge clr) begin
      if (!clr) state <= IDLE;
      else      state <= nxt;
   end

   // next-state: play low always wins; HIT leaves when the counter runs out
   always_comb begin
      nxt = state;
      if (!play) begin
         nxt = IDLE;
      end else begin
         case (state)
            IDLE:    nxt = ALIVE;
            ALIVE:   if (hit_any) nxt = (lives == 2'd1) ? DEAD : HIT;
            HIT:     if (tick && inv_cnt <= INV_W'(1)) nxt = ALIVE;
            DEAD:    nxt = DEAD;
            default: nxt = IDLE;
         endcase
      end
   end

   // per-state enables for the datapath
   always_comb begin
      active  = play && (state != IDLE);
      move_en = play && tick && (state == ALIVE || state == HIT);
      fire_ok = play && (state == ALIVE) && fire_rise && (projectiles_y == '0);
      hit_acc = play && (state == ALIVE) && hit_any;
   end

   // ship, projectile, lives and invulnerability counter
   always_ff @(posedge clk_4 or negedge clr) begin
      if (!clr) begin
         player_x      <= XSTRT_V;
         projectiles_x <= '0;
         projectiles_y <= '0;
         lives         <= LIVES_V;
         player_hit    <= 1'b0;
         game_over     <= 1'b0;
         inv_cnt       <= '0;
      end else if (!play) begin
         player_x      <= XSTRT_V;
         projectiles_x <= '0;
         projectiles_y <= '0;
         lives         <= LIVES_V;
         player_hit    <= 1'b0;
         game_over     <= 1'b0;
         inv_cnt       <= '0;
      end else begin
         player_hit <= hit_acc;
         game_over  <= (nxt == DEAD);

         if (move_en && (btn_left ^ btn_right)) begin
            if (btn_left && player_x > XMIN_V)  player_x <= player_x - 10'd1;
            if (btn_right && player_x < XMAX_V) player_x <= player_x + 10'd1;
         end

         // collision beats fire, fire beats flight
         if (active) begin
            if (collision) begin
               projectiles_y <= '0;
            end else if (fire_ok) begin
               projectiles_x <= player_x;
               projectiles_y <= SHOT_Y;
            end else if (tick && projectiles_y != '0) begin
               projectiles_y <= (projectiles_y <= STEP_V) ? 10'd0 : projectiles_y - STEP_V;
            end
         end

         if (hit_acc) begin
            lives   <= lives - 2'd1;
            inv_cnt <= INV_V;
         end else if (state == HIT && tick && inv_cnt != '0) begin
            inv_cnt <= inv_cnt - INV_W'(1);
         end
      end
   end

endmodule

// File: doc/player_cannon.md
# player_cannon

Player-side counterpart of the invader formation block. It owns the player ship and the single player projectile, publishes that projectile as `projectiles_x`/`projectiles_y` for the formation's collision logic, and checks the formation's packed enemy projectile bus against the ship. It also keeps the lives count and drives the game-over flag read by the top level and display.

## Interface
Parameters:
- `PLAYER_Y`, 440: fixed ship row, in pixels.
- `X_MIN` / `X_MAX` / `X_START`, 100 / 540 / 320: ship x clamp limits and spawn position.
- `LIVES`, 3: starting lives (1–3).
- `SHOT_STEP`, 4: pixels the projectile rises per `tick`.
- `INVULN_TICKS`, 60: length of the post-hit invulnerability window, in ticks.
- `HIT_HALF_W` / `HIT_H`, 10 / 20: ship hit-box half-width and height.

Ports:
- `clk_4`, in, 1: game logic clock.
- `clr`, in, 1: reset, asynchronous, active-low.
- `play`, in, 1: game running; low forces the idle state.
- `tick`, in, 1: one-cycle motion strobe.
- `btn_left`, `btn_right`, `btn_fire`, in, 1 each: synchronized buttons.
- `collision`, in, 1: formation reports that the player projectile hit an invader.
- `enemy_projectiles_x`, in, 46: slots [8:0], [17:9], [26:18], [35:27], [45:36].
- `enemy_projectiles_y`, in, 45: five 9-bit slots at [9i+8:9i]; a value of 0 means the slot is inactive.
- `projectiles_x`, `projectiles_y`, out, 10 each: player projectile; y = 0 means inactive.
- `player_x`, out, 10: ship centre x.
- `lives`, out, 2: remaining lives.
- `player_hit`, out, 1: one-cycle pulse on each accepted hit.
- `game_over`, out, 1: level output; high in DEAD.

## Operation
- States are IDLE, ALIVE, HIT, DEAD.
- IDLE:
  - Outputs hold their reset values.
  - `play` = 1 moves the block to ALIVE.
- Any state with `play` = 0 returns synchronously to IDLE and restores the reset values.
- Movement applies in ALIVE and HIT, on `tick` only:
  - `btn_left` alone: `player_x` − 1, clamped at `X_MIN`.
  - `btn_right` alone: `player_x` + 1, clamped at `X_MAX`.
  - Both or neither: no movement.
- Fire:
  - Detected as a `btn_fire` rising edge.
  - Accepted only in ALIVE while `projectiles_y` = 0.
  - Loads `projectiles_x` = `player_x` and `projectiles_y` = `PLAYER_Y` − 10.
  - An edge seen while the projectile is in flight is dropped, not queued.
- Projectile flight, on `tick` while active:
  - If `projectiles_y` ≤ `SHOT_STEP`, clear to 0.
  - Otherwise subtract `SHOT_STEP`.
- `collision` = 1 clears `projectiles_y` to 0 the next cycle. This takes priority over tick motion and fire.
- Hit test, per slot i:
  - Slot must be active: y_i ≠ 0.
  - Horizontal: |x_i − `player_x`| < `HIT_HALF_W`.
  - Vertical: `PLAYER_Y` ≤ y_i < `PLAYER_Y` + `HIT_H`.
  - The five results are ORed.
- Hit acceptance, in ALIVE only:
  - Decrement `lives` and pulse `player_hit`.
  - If `lives` was 1: go to DEAD with `lives` = 0.
  - Otherwise: go to HIT and load the invulnerability counter with `INVULN_TICKS`.
- HIT:
  - Hits are ignored and fire is blocked.
  - The counter decrements on `tick`; reaching 0 returns to ALIVE.
- DEAD:
  - `game_over` = 1.
  - Movement and fire are frozen, but an in-flight projectile keeps moving.
  - Leaving DEAD requires `play` = 0.
- Arithmetic: all x comparisons use 11-bit zero-extended differences, so there is no unsigned wrap. Slot 4 x is 10 bits; slots 0–3 are zero-extended from 9 bits.

## Timing
- Reset values: `player_x` = `X_START`, `projectiles_x` = `projectiles_y` = 0, `lives` = `LIVES`, `player_hit` = 0, `game_over` = 0, state IDLE.
- All outputs are registered.
- Fire edge at cycle n → projectile loaded at n+1.
- Hit test registers its inputs; `player_hit` asserts one cycle after the enemy slot satisfies the test.
- Simultaneous hits in several slots in one cycle: exactly one life is lost.
- `play` deassert mid-flight: the projectile clears on the next edge.
- Asynchronous `clr` at any time: all outputs return to their reset values immediately.

## Structure
- `game_pkg` holds:
  - Slot count (5).
  - Slot bit offsets and widths.
  - Screen constants (480 rows, 640 columns).
  - State enum `cannon_state_t`.
- One sub-module, `slot_hit_cmp`: the combinational box test for one enemy slot, instantiated 5 times.
- The edge detector, FSM, and counters live in `player_cannon`.

## Test plan
- Reset, then `play` = 1: `player_x` = 320, `lives` = 3, `projectiles_y` = 0; state ALIVE after 1 cycle.
- Fire at `player_x` = 320, then 10 ticks: `projectiles_y` = 430 → 390. A second fire edge mid-flight is ignored. Projectile at y = 2 clears to 0 on the next tick.
- Fire, then pulse `collision`: `projectiles_y` = 0 next cycle, and a new fire is accepted on the following edge.
- Slot 4 enemy projectile at x = 325, y = 445 with `player_x` = 320: `player_hit` pulses once, `lives` = 2. The same input held during 60 ticks produces no further hit; a hit is accepted again after the counter expires.
- Hit slots 1 and 3 in the same cycle with `lives` = 1: `lives` = 0 and `game_over` = 1 after one pulse. `play` = 0 then returns to the reset values.
- Hold `btn_left` for 300 ticks: `player_x` stops at 100. Both buttons held: no motion. `clr` low mid-flight: all outputs at reset values before the next clock edge.
